// File: rtl/palette_arbiter.sv
// rtl/palette_arbiter.sv - four-requester palette lookup arbiter with two-stage response pipeline
module palette_arbiter #(
  parameter logic [11:0] TRANSPARENT_RGB = 12'hF0B,
  parameter int          FIXED_PRIORITY  = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [15:0] req_index,
  input  logic        flush,
  output logic [3:0]  grant,
  output logic [3:0]  pal_index,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [3:0]  rsp_red,
  output logic [3:0]  rsp_green,
  output logic [3:0]  rsp_blue,
  output logic        rsp_transparent
);

  // Stage-A bookkeeping: lookup in flight towards the palette, and whose it is.
  logic       a_valid;
  logic [1:0] a_id;
  logic [1:0] last_winner;

  logic [3:0] eligible;
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;

  // Pick the winner: a requester granted this cycle sits out one round so
  // the same requester cannot be granted on back-to-back cycles.
  always_comb begin
    eligible  = req & ~grant;
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (FIXED_PRIORITY != 0) begin
        cand = 2'(k);
      end else begin
        cand = last_winner + 2'(k + 1);
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Stage A: register grant, the winner's palette index and its id.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant       <= 4'b0000;
      pal_index   <= 4'h0;
      a_valid     <= 1'b0;
      a_id        <= 2'd0;
      last_winner <= 2'd3;
    end else if (flush) begin
      grant   <= 4'b0000;
      a_valid <= 1'b0;
    end else begin
      a_valid <= win_found;
      if (win_found) begin
        grant       <= 4'b0001 << win_id;
        pal_index   <= req_index[{win_id, 2'b00} +: 4];
        a_id        <= win_id;
        last_winner <= win_id;
      end else begin
        grant <= 4'b0000;
      end
    end
  end

  // Stage B: capture the palette ROM output for the lookup issued last cycle;
  // response fields only move when a lookup actually completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid       <= 1'b0;
      rsp_id          <= 2'd0;
      rsp_red         <= 4'h0;
      rsp_green       <= 4'h0;
      rsp_blue        <= 4'h0;
      rsp_transparent <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= a_valid;
      if (a_valid) begin
        rsp_id          <= a_id;
        rsp_red         <= pal_red;
        rsp_green       <= pal_green;
        rsp_blue        <= pal_blue;
        rsp_transparent <= ({pal_red, pal_green, pal_blue} == TRANSPARENT_RGB);
      end
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// tb/tb_palette_arbiter.sv - self-checking bench for palette_arbiter (round-robin and fixed instances)
module tb_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] req_index = 16'h0000;
  logic        flush = 1'b0;

  logic [3:0]  dut_grant [2];
  logic [3:0]  dut_pidx  [2];
  logic [3:0]  dut_pr    [2];
  logic [3:0]  dut_pg    [2];
  logic [3:0]  dut_pb    [2];
  logic        dut_rv    [2];
  logic [1:0]  dut_rid   [2];
  logic [3:0]  dut_rr    [2];
  logic [3:0]  dut_rg    [2];
  logic [3:0]  dut_rb    [2];
  logic        dut_rt    [2];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 Clk = ~Clk;

  function automatic logic [11:0] pal_rom(input logic [3:0] i);
    case (i)
      4'h0:    return 12'hF0B;
      4'h4:    return 12'h941;
      default: return {i, ~i, i + 4'd3};
    endcase
  endfunction

  assign {dut_pr[0], dut_pg[0], dut_pb[0]} = pal_rom(dut_pidx[0]);
  assign {dut_pr[1], dut_pg[1], dut_pb[1]} = pal_rom(dut_pidx[1]);

  palette_arbiter #(.TRANSPARENT_RGB(12'hF0B), .FIXED_PRIORITY(0)) u_rr (
    .Clk(Clk), .Reset(Reset), .req(req), .req_index(req_index), .flush(flush),
    .grant(dut_grant[0]), .pal_index(dut_pidx[0]),
    .pal_red(dut_pr[0]), .pal_green(dut_pg[0]), .pal_blue(dut_pb[0]),
    .rsp_valid(dut_rv[0]), .rsp_id(dut_rid[0]),
    .rsp_red(dut_rr[0]), .rsp_green(dut_rg[0]), .rsp_blue(dut_rb[0]),
    .rsp_transparent(dut_rt[0])
  );

  palette_arbiter #(.TRANSPARENT_RGB(12'hF0B), .FIXED_PRIORITY(1)) u_fx (
    .Clk(Clk), .Reset(Reset), .req(req), .req_index(req_index), .flush(flush),
    .grant(dut_grant[1]), .pal_index(dut_pidx[1]),
    .pal_red(dut_pr[1]), .pal_green(dut_pg[1]), .pal_blue(dut_pb[1]),
    .rsp_valid(dut_rv[1]), .rsp_id(dut_rid[1]),
    .rsp_red(dut_rr[1]), .rsp_green(dut_rg[1]), .rsp_blue(dut_rb[1]),
    .rsp_transparent(dut_rt[1])
  );

  // Behavioural model: what each output must show after the next edge.
  typedef struct {
    logic [3:0]  grant;
    logic [3:0]  idx;
    logic [1:0]  last;
    logic        pv;
    logic [1:0]  pid;
    logic        rv;
    logic [1:0]  rid;
    logic [11:0] rgb;
    logic        rt;
  } mstate_t;

  mstate_t m [2];

  function automatic mstate_t step(input mstate_t s, input bit fx, input logic rs,
                                   input logic fl, input logic [3:0] r, input logic [15:0] ri);
    mstate_t n;
    int c;
    n = s;
    if (rs) begin
      n.grant = 0; n.idx = 0; n.last = 2'd3; n.pv = 0; n.pid = 0;
      n.rv = 0; n.rid = 0; n.rgb = 0; n.rt = 0;
      return n;
    end
    if (fl) begin
      n.grant = 0; n.pv = 0; n.rv = 0;
      return n;
    end
    n.rv = s.pv;
    if (s.pv) begin
      n.rid = s.pid;
      n.rgb = pal_rom(s.idx);
      n.rt  = (n.rgb == 12'hF0B);
    end
    n.grant = 0;
    n.pv    = 0;
    for (int k = 0; k < 4; k++) begin
      c = fx ? k : (int'(s.last) + 1 + k) % 4;
      if (!n.pv && r[c] && !s.grant[c]) begin
        n.pv    = 1'b1;
        n.grant = 4'(1 << c);
        n.idx   = ri[4*c +: 4];
        n.pid   = 2'(c);
        n.last  = 2'(c);
      end
    end
    return n;
  endfunction

  // Advance the model on every rising edge from the same inputs the DUTs see.
  always @(posedge Clk) begin
    m[0] <= step(m[0], 1'b0, Reset, flush, req, req_index);
    m[1] <= step(m[1], 1'b1, Reset, flush, req, req_index);
  end

  task automatic chk(input string nm, input int u, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] actual=%h required=%h at %0t", nm, u, act, exp, $time);
  endtask

  // Compare process: every DUT output against the model, every cycle.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk("m_grant", u, 12'(dut_grant[u]), 12'(m[u].grant));
        chk("m_pal_index", u, 12'(dut_pidx[u]), 12'(m[u].idx));
        chk("m_rsp_valid", u, 12'(dut_rv[u]), 12'(m[u].rv));
        chk("m_rsp_id", u, 12'(dut_rid[u]), 12'(m[u].rid));
        chk("m_rsp_rgb", u, {dut_rr[u], dut_rg[u], dut_rb[u]}, m[u].rgb);
        chk("m_rsp_transparent", u, 12'(dut_rt[u]), 12'(m[u].rt));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1; req = 4'b0000; flush = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [15:0] ri;
    logic        fl;
    logic        rs;
  } vec_t;

  logic [3:0] exp_rr_g [5];
  logic [3:0] exp_fx_g [5];
  vec_t       vt [14];

  initial begin
    exp_rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_fx_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    vt = '{
      '{4'b1010, 16'h7A3C, 1'b0, 1'b0}, '{4'b1010, 16'h5A3C, 1'b0, 1'b0},
      '{4'b1010, 16'h1234, 1'b0, 1'b0}, '{4'b0110, 16'h4E60, 1'b0, 1'b0},
      '{4'b0110, 16'h4E60, 1'b1, 1'b0}, '{4'b0110, 16'h9E60, 1'b0, 1'b0},
      '{4'b1111, 16'hFEDC, 1'b0, 1'b0}, '{4'b1111, 16'h0400, 1'b1, 1'b1},
      '{4'b1001, 16'h0408, 1'b0, 1'b0}, '{4'b1001, 16'hB40C, 1'b0, 1'b0},
      '{4'b0000, 16'hFFFF, 1'b0, 1'b0}, '{4'b0000, 16'hFFFF, 1'b0, 1'b0},
      '{4'b0100, 16'h0000, 1'b0, 1'b0}, '{4'b0000, 16'h0000, 1'b0, 1'b0}
    };

    tick();
    do_reset();
    chk_en = 1'b1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_grant", u, 12'(dut_grant[u]), 12'h0);
      chk("rst_pal_index", u, 12'(dut_pidx[u]), 12'h0);
      chk("rst_rsp_valid", u, 12'(dut_rv[u]), 12'h0);
    end

    // Single request from requester 2 with index 4.
    req = 4'b0100; req_index = 16'h0400;
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("single_grant_c1", u, 12'(dut_grant[u]), 12'h004);
      chk("single_pidx_c1", u, 12'(dut_pidx[u]), 12'h004);
      chk("single_rv_c1", u, 12'(dut_rv[u]), 12'h0);
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("single_rv_c2", u, 12'(dut_rv[u]), 12'h1);
      chk("single_id_c2", u, 12'(dut_rid[u]), 12'h2);
      chk("single_rgb_c2", u, {dut_rr[u], dut_rg[u], dut_rb[u]}, 12'h941);
      chk("single_tr_c2", u, 12'(dut_rt[u]), 12'h0);
      chk("single_grant_c2", u, 12'(dut_grant[u]), 12'h0);
    end
    tick();
    chk("single_grant_c3", 0, 12'(dut_grant[0]), 12'h004);
    req = 4'b0000;
    tick(); tick(); tick();

    // All four requesting: round-robin rotation vs fixed alternation.
    do_reset();
    req = 4'b1111; req_index = 16'h3210;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_seq", i, 12'(dut_grant[0]), 12'(exp_rr_g[i]));
      chk("fx_grant_seq", i, 12'(dut_grant[1]), 12'(exp_fx_g[i]));
      if (i >= 1) begin
        chk("rr_rsp_valid_seq", i, 12'(dut_rv[0]), 12'h1);
        chk("rr_rsp_id_seq", i, 12'(dut_rid[0]), 12'((i - 1) % 4));
      end
      tick();
    end
    req = 4'b0000;
    tick(); tick();

    // Fixed priority with requesters 0 and 1.
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("fx_0011_grant", i, 12'(dut_grant[1]), 12'(exp_fx_g[i]));
      tick();
    end
    req = 4'b0000;
    tick(); tick();

    // Transparency key from palette index 0.
    do_reset();
    req = 4'b0010; req_index = 16'h0000;
    tick();
    req = 4'b0000;
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("transp_flag", u, 12'(dut_rt[u]), 12'h1);
      chk("transp_rgb", u, {dut_rr[u], dut_rg[u], dut_rb[u]}, 12'hF0B);
      chk("transp_id", u, 12'(dut_rid[u]), 12'h1);
    end
    tick();

    // Flush mid-pipeline, then reset mid-pipeline.
    do_reset();
    req = 4'b0001; req_index = 16'h0005;
    tick();
    chk("flush_pre_grant", 0, 12'(dut_grant[0]), 12'h001);
    req = 4'b0000; flush = 1'b1;
    tick();
    chk("flush_grant", 0, 12'(dut_grant[0]), 12'h0);
    chk("flush_rv", 0, 12'(dut_rv[0]), 12'h0);
    flush = 1'b0;
    tick();
    chk("flush_rv_after", 0, 12'(dut_rv[0]), 12'h0);
    req = 4'b1111;
    tick();
    chk("flush_keeps_last", 0, 12'(dut_grant[0]), 12'h002);
    req = 4'b0100;
    tick(); tick();
    Reset = 1'b1; req = 4'b0000;
    tick();
    chk("rst_mid_grant", 0, 12'(dut_grant[0]), 12'h0);
    chk("rst_mid_pidx", 0, 12'(dut_pidx[0]), 12'h0);
    chk("rst_mid_rv", 0, 12'(dut_rv[0]), 12'h0);
    chk("rst_mid_rgb", 0, {dut_rr[0], dut_rg[0], dut_rb[0]}, 12'h0);
    Reset = 1'b0;
    tick();
    chk("rst_mid_rv_after", 0, 12'(dut_rv[0]), 12'h0);
    req = 4'b1111;
    tick();
    chk("rst_rr_restart", 0, 12'(dut_grant[0]), 12'h001);
    req = 4'b0000;
    tick(); tick();

    // Mixed directed vectors, checked by the model every cycle.
    for (int i = 0; i < 14; i++) begin
      req = vt[i].r; req_index = vt[i].ri; flush = vt[i].fl; Reset = vt[i].rs;
      tick();
    end
    Reset = 1'b0; flush = 1'b0; req = 4'b0000;
    tick(); tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
